// File: rtl/fpadd_dispatch.sv
// rtl/fpadd_dispatch.sv - request FIFO and single-issue sequencer for a packed fp16/fp32 adder
module fpadd_dispatch #(
   parameter int PARAM_FIFO_DEPTH = 2,
   parameter int PARAM_TIMEOUT    = 15
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         req_valid,
   output logic         req_ready,
   input  logic [127:0] req_s0,
   input  logic [127:0] req_s1,
   input  logic         req_mode,
   input  logic [3:0]   req_tag,
   output logic         rsp_valid,
   input  logic         rsp_ready,
   output logic [127:0] rsp_data,
   output logic [3:0]   rsp_tag,
   output logic         rsp_err,
   output logic         fp_inst_valid,
   output logic [127:0] fp_s0,
   output logic [127:0] fp_s1,
   output logic         fp_mode,
   input  logic         fp_idle,
   input  logic [127:0] fp_result,
   output logic         busy
);

   localparam int PW = $clog2(PARAM_FIFO_DEPTH);
   localparam int CW = $clog2(PARAM_FIFO_DEPTH + 1);
   localparam int TW = $clog2(PARAM_TIMEOUT + 1);

   typedef enum logic [2:0] {
      IDLE,
      ISSUE,
      WAIT_BUSY,
      WAIT_DONE,
      RESP
   } state_e;

   state_e          state_q, state_d;

   logic [127:0]    fifo_s0_q   [PARAM_FIFO_DEPTH];
   logic [127:0]    fifo_s0_d   [PARAM_FIFO_DEPTH];
   logic [127:0]    fifo_s1_q   [PARAM_FIFO_DEPTH];
   logic [127:0]    fifo_s1_d   [PARAM_FIFO_DEPTH];
   logic            fifo_mode_q [PARAM_FIFO_DEPTH];
   logic            fifo_mode_d [PARAM_FIFO_DEPTH];
   logic [3:0]      fifo_tag_q  [PARAM_FIFO_DEPTH];
   logic [3:0]      fifo_tag_d  [PARAM_FIFO_DEPTH];

   logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]   count_q, count_d;

   logic [3:0]      inflight_tag_q, inflight_tag_d;
   logic [TW-1:0]   tmo_q, tmo_d;
   logic [127:0]    rsp_data_q, rsp_data_d;
   logic [3:0]      rsp_tag_q, rsp_tag_d;
   logic            rsp_err_q, rsp_err_d;

   logic            push;
   logic            pop;
   logic            tmo_hit;
   logic            op_done;
   logic            op_abort;

   // handshake qualifiers shared by the FIFO, the FSM and the response capture
   always_comb begin
      req_ready = (count_q < CW'(PARAM_FIFO_DEPTH));
      push      = req_valid && req_ready;
      pop       = (state_q == ISSUE) && fp_idle;
      tmo_hit   = (tmo_q == TW'(PARAM_TIMEOUT - 1));
      op_done   = (state_q == WAIT_DONE) && fp_idle;
      op_abort  = tmo_hit && ((state_q == WAIT_BUSY) || ((state_q == WAIT_DONE) && !fp_idle));
   end

   // FIFO pointers wrap naturally because the depth is a power of two
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) begin
         wr_ptr_d = wr_ptr_q + PW'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PW'(1);
      end
      case ({push, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   // FIFO storage write at the tail
   always_comb begin
      fifo_s0_d   = fifo_s0_q;
      fifo_s1_d   = fifo_s1_q;
      fifo_mode_d = fifo_mode_q;
      fifo_tag_d  = fifo_tag_q;
      if (push) begin
         fifo_s0_d[wr_ptr_q]   = req_s0;
         fifo_s1_d[wr_ptr_q]   = req_s1;
         fifo_mode_d[wr_ptr_q] = req_mode;
         fifo_tag_d[wr_ptr_q]  = req_tag;
      end
   end

   // FIFO storage needs no reset: entries are only read behind a valid count
   always_ff @(posedge clk) begin
      fifo_s0_q   <= fifo_s0_d;
      fifo_s1_q   <= fifo_s1_d;
      fifo_mode_q <= fifo_mode_d;
      fifo_tag_q  <= fifo_tag_d;
   end

   // adder operands come straight from the head entry
   always_comb begin
      fp_s0   = fifo_s0_q[rd_ptr_q];
      fp_s1   = fifo_s1_q[rd_ptr_q];
      fp_mode = fifo_mode_q[rd_ptr_q];
   end

   // state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // next-state logic; completion wins over timeout in the same cycle
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (count_q != '0) state_d = ISSUE;
         end
         ISSUE: begin
            if (fp_idle) state_d = WAIT_BUSY;
         end
         WAIT_BUSY: begin
            if (op_abort)      state_d = RESP;
            else if (!fp_idle) state_d = WAIT_DONE;
         end
         WAIT_DONE: begin
            if (op_done || op_abort) state_d = RESP;
         end
         RESP: begin
            if (rsp_ready) state_d = (count_d != '0) ? ISSUE : IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // FSM outputs
   always_comb begin
      fp_inst_valid = (state_q == ISSUE) && fp_idle;
      rsp_valid     = (state_q == RESP);
      busy          = (state_q != IDLE) || (count_q != '0);
   end

   // in-flight tag, timeout counter and response capture
   always_comb begin
      inflight_tag_d = inflight_tag_q;
      tmo_d          = tmo_q;
      rsp_data_d     = rsp_data_q;
      rsp_tag_d      = rsp_tag_q;
      rsp_err_d      = rsp_err_q;
      if (pop) begin
         inflight_tag_d = fifo_tag_q[rd_ptr_q];
         tmo_d          = '0;
      end
      if ((state_q == WAIT_BUSY) || (state_q == WAIT_DONE)) begin
         tmo_d = tmo_q + TW'(1);
      end
      if (op_done) begin
         rsp_data_d = fp_result;
         rsp_err_d  = 1'b0;
         rsp_tag_d  = inflight_tag_q;
      end else if (op_abort) begin
         rsp_data_d = '0;
         rsp_err_d  = 1'b1;
         rsp_tag_d  = inflight_tag_q;
      end
   end

   // control and datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q       <= '0;
         rd_ptr_q       <= '0;
         count_q        <= '0;
         inflight_tag_q <= '0;
         tmo_q          <= '0;
         rsp_data_q     <= '0;
         rsp_tag_q      <= '0;
         rsp_err_q      <= 1'b0;
      end else begin
         wr_ptr_q       <= wr_ptr_d;
         rd_ptr_q       <= rd_ptr_d;
         count_q        <= count_d;
         inflight_tag_q <= inflight_tag_d;
         tmo_q          <= tmo_d;
         rsp_data_q     <= rsp_data_d;
         rsp_tag_q      <= rsp_tag_d;
         rsp_err_q      <= rsp_err_d;
      end
   end

   assign rsp_data = rsp_data_q;
   assign rsp_tag  = rsp_tag_q;
   assign rsp_err  = rsp_err_q;

endmodule

// File: tb/tb_fpadd_dispatch.sv
// tb/tb_fpadd_dispatch.sv - directed and randomized checks of fpadd_dispatch against a 4-cycle adder model
module tb_fpadd_dispatch;

   localparam int DEPTH = 2;
   localparam int TMO   = 15;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         req_valid = 1'b0;
   logic         req_ready;
   logic [127:0] req_s0 = '0;
   logic [127:0] req_s1 = '0;
   logic         req_mode = 1'b0;
   logic [3:0]   req_tag = '0;
   logic         rsp_valid;
   logic         rsp_ready = 1'b0;
   logic [127:0] rsp_data;
   logic [3:0]   rsp_tag;
   logic         rsp_err;
   logic         fp_inst_valid;
   logic [127:0] fp_s0;
   logic [127:0] fp_s1;
   logic         fp_mode;
   logic         fp_idle;
   logic [127:0] fp_result;
   logic         busy;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   typedef struct {
      logic [3:0]   tag;
      logic [127:0] data;
      logic         err;
   } rsp_t;
   rsp_t exp_q[$];

   fpadd_dispatch #(
      .PARAM_FIFO_DEPTH(DEPTH),
      .PARAM_TIMEOUT   (TMO)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_s0       (req_s0),
      .req_s1       (req_s1),
      .req_mode     (req_mode),
      .req_tag      (req_tag),
      .rsp_valid    (rsp_valid),
      .rsp_ready    (rsp_ready),
      .rsp_data     (rsp_data),
      .rsp_tag      (rsp_tag),
      .rsp_err      (rsp_err),
      .fp_inst_valid(fp_inst_valid),
      .fp_s0        (fp_s0),
      .fp_s1        (fp_s1),
      .fp_mode      (fp_mode),
      .fp_idle      (fp_idle),
      .fp_result    (fp_result),
      .busy         (busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // floating-point helpers: widen to double, add, narrow back (normal numbers)
   function automatic real h2r(input logic [15:0] h);
      if (h[14:0] == 15'd0) return 0.0;
      return $bitstoreal({h[15], 11'(h[14:10]) + 11'd1008, h[9:0], 42'd0});
   endfunction

   function automatic logic [15:0] r2h(input real r);
      logic [63:0] b;
      b = $realtobits(r);
      if (r == 0.0) return 16'd0;
      return {b[63], 5'(b[62:52] - 11'd1008), b[51:42]};
   endfunction

   function automatic real s2r(input logic [31:0] s);
      if (s[30:0] == 31'd0) return 0.0;
      return $bitstoreal({s[31], 11'(s[30:23]) + 11'd896, s[22:0], 29'd0});
   endfunction

   function automatic logic [31:0] r2s(input real r);
      logic [63:0] b;
      b = $realtobits(r);
      if (r == 0.0) return 32'd0;
      return {b[63], 8'(b[62:52] - 11'd896), b[51:29]};
   endfunction

   function automatic logic [127:0] add128(input logic [127:0] a, input logic [127:0] b, input logic m);
      logic [127:0] r;
      r = '0;
      if (m) begin
         for (int i = 0; i < 4; i++) r[i*32 +: 32] = r2s(s2r(a[i*32 +: 32]) + s2r(b[i*32 +: 32]));
      end else begin
         for (int i = 0; i < 8; i++) r[i*16 +: 16] = r2h(h2r(a[i*16 +: 16]) + h2r(b[i*16 +: 16]));
      end
      return r;
   endfunction

   // adder model: idle again four cycles after the issue cycle
   bit           force_idle = 1'b0;
   bit           force_busy = 1'b0;
   int           busy_cnt   = 0;
   logic [127:0] mock_res   = '0;

   always @(posedge clk) begin
      if (fp_inst_valid && !force_idle) begin
         busy_cnt <= 3;
         mock_res <= add128(fp_s0, fp_s1, fp_mode);
      end else if (busy_cnt > 0) begin
         busy_cnt <= busy_cnt - 1;
      end
   end

   assign fp_idle   = force_busy ? 1'b0 : (force_idle ? 1'b1 : (busy_cnt == 0));
   assign fp_result = mock_res;

   task automatic chk(input string name, input logic [127:0] obs, input logic [127:0] exp);
      n_tests++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
      end
   endtask

   task automatic reset_checks(input string name);
      chk({name, "_rsp_valid"}, 128'(rsp_valid), 128'(0));
      chk({name, "_rsp_err"}, 128'(rsp_err), 128'(0));
      chk({name, "_rsp_tag"}, 128'(rsp_tag), 128'(0));
      chk({name, "_rsp_data"}, rsp_data, 128'(0));
      chk({name, "_fp_inst_valid"}, 128'(fp_inst_valid), 128'(0));
      chk({name, "_req_ready"}, 128'(req_ready), 128'(1));
      chk({name, "_busy"}, 128'(busy), 128'(0));
   endtask

   task automatic send(input logic [3:0] tag, input logic m, input logic [127:0] a,
                       input logic [127:0] b, input bit err, output int t_acc);
      int   n;
      rsp_t e;
      req_valid = 1'b1;
      req_tag   = tag;
      req_mode  = m;
      req_s0    = a;
      req_s1    = b;
      n = 0;
      @(negedge clk);
      while (!req_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("req_accept_wait", 128'(n < 100), 128'(1));
      t_acc  = cyc;
      e.tag  = tag;
      e.data = err ? 128'd0 : add128(a, b, m);
      e.err  = err;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      req_valid = 1'b0;
   endtask

   task automatic watch(input int budget, output int t_inst, output int n_inst, output int t_rsp);
      t_inst = -1;
      n_inst = 0;
      t_rsp  = -1;
      for (int k = 0; k < budget; k++) begin
         @(negedge clk);
         if (fp_inst_valid) begin
            if (t_inst < 0) t_inst = cyc;
            n_inst++;
         end
         if (rsp_valid) begin
            t_rsp = cyc;
            break;
         end
         @(posedge clk);
         #1;
      end
      chk("rsp_wait", 128'(t_rsp >= 0), 128'(1));
   endtask

   task automatic take(input string name, input bit keep);
      rsp_t e;
      chk({name, "_valid"}, 128'(rsp_valid), 128'(1));
      chk({name, "_expected"}, 128'(exp_q.size() != 0), 128'(1));
      if (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         chk({name, "_tag"}, 128'(rsp_tag), 128'(e.tag));
         chk({name, "_data"}, rsp_data, e.data);
         chk({name, "_err"}, 128'(rsp_err), 128'(e.err));
      end
      rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      if (!keep) rsp_ready = 1'b0;
   endtask

   function automatic logic [127:0] rnd128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   initial begin
      #3000000;
      $display("FAIL watchdog expired observed=running expected=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      int t, t2, ti, ni, tr, tr2, cnt_a, cnt_b;
      logic [127:0] a, b;

      // reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset_checks("rst");
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // fp16 1.0 + 1.0, latency from accept to issue and response
      rsp_ready = 1'b1;
      a = {8{16'h3C00}};
      send(4'd5, 1'b0, a, a, 1'b0, t);
      watch(30, ti, ni, tr);
      chk("fp16_inst_cycle", 128'(ti), 128'(t + 2));
      chk("fp16_inst_pulses", 128'(ni), 128'(1));
      chk("fp16_rsp_cycle", 128'(tr), 128'(t + 7));
      chk("fp16_const_data", rsp_data, {8{16'h4000}});
      take("fp16", 1'b1);

      // fp32 1.0 + 2.0
      a = {4{32'h3F800000}};
      b = {4{32'h40000000}};
      send(4'd9, 1'b1, a, b, 1'b0, t);
      watch(30, ti, ni, tr);
      chk("fp32_rsp_cycle", 128'(tr), 128'(t + 7));
      chk("fp32_const_data", rsp_data, {4{32'h40400000}});
      take("fp32", 1'b1);

      // back-to-back throughput with rsp_ready held high
      send(4'd6, 1'b0, rnd128(), rnd128(), 1'b0, t);
      send(4'd8, 1'b1, rnd128(), rnd128(), 1'b0, t2);
      watch(30, ti, ni, tr);
      take("thr_a", 1'b1);
      watch(30, ti, ni, tr2);
      take("thr_b", 1'b1);
      chk("thr_interval", 128'(tr2 - tr), 128'(6));
      rsp_ready = 1'b0;

      // FIFO full while a response is held; third request waits for release
      send(4'hA, 1'b0, rnd128(), rnd128(), 1'b0, t);
      watch(30, ti, ni, tr);
      @(posedge clk);
      #1;
      send(4'd1, 1'b0, rnd128(), rnd128(), 1'b0, t);
      send(4'd2, 1'b1, rnd128(), rnd128(), 1'b0, t);
      req_valid = 1'b1;
      req_tag   = 4'd3;
      cnt_a = 0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         if (req_ready) cnt_a++;
         @(posedge clk);
         #1;
      end
      chk("full_ready_low", 128'(cnt_a), 128'(0));
      req_valid = 1'b0;
      @(negedge clk);
      take("full_held", 1'b0);
      send(4'd3, 1'b0, rnd128(), rnd128(), 1'b0, t);
      for (int k = 1; k <= 3; k++) begin
         watch(30, ti, ni, tr);
         chk("order_tag", 128'(rsp_tag), 128'(k));
         take("order", 1'b0);
      end

      // adder never goes busy: timeout response then back to idle
      force_idle = 1'b1;
      send(4'd7, 1'b1, rnd128(), rnd128(), 1'b1, t);
      watch(60, ti, ni, tr);
      chk("tmo_cycles", 128'(tr - ti), 128'(TMO + 1));
      chk("tmo_err", 128'(rsp_err), 128'(1));
      chk("tmo_data_zero", rsp_data, 128'(0));
      take("tmo", 1'b0);
      force_idle = 1'b0;
      @(negedge clk);
      chk("tmo_recover_idle", 128'(busy), 128'(0));
      @(posedge clk);
      #1;

      // adder busy when work arrives: issue waits, then one pulse
      force_busy = 1'b1;
      send(4'd4, 1'b0, rnd128(), rnd128(), 1'b0, t);
      cnt_a = 0;
      cnt_b = 0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         if (fp_inst_valid) cnt_a++;
         if (busy) cnt_b++;
         @(posedge clk);
         #1;
      end
      chk("stall_no_inst", 128'(cnt_a), 128'(0));
      chk("stall_busy", 128'(cnt_b), 128'(8));
      force_busy = 1'b0;
      watch(30, ti, ni, tr);
      chk("stall_one_pulse", 128'(ni), 128'(1));
      take("stall", 1'b0);

      // randomized pairs with random response back-pressure
      for (int i = 0; i < 6; i++) begin
         send(4'($urandom), 1'($urandom), rnd128(), rnd128(), 1'b0, t);
         send(4'($urandom), 1'($urandom), rnd128(), rnd128(), 1'b0, t);
         for (int j = 0; j < 2; j++) begin
            watch(40, ti, ni, tr);
            repeat ($urandom_range(0, 3)) begin
               @(posedge clk);
               @(negedge clk);
            end
            take("rand", 1'b0);
         end
      end

      // reset while waiting for the adder with another request queued
      send(4'hB, 1'b0, rnd128(), rnd128(), 1'b0, t);
      send(4'hC, 1'b1, rnd128(), rnd128(), 1'b0, t);
      cnt_a = 0;
      for (int k = 0; k < 20 && !fp_inst_valid; k++) begin
         @(negedge clk);
         cnt_a++;
         if (!fp_inst_valid) begin
            @(posedge clk);
            #1;
         end
      end
      chk("mid_issue_seen", 128'(fp_inst_valid), 128'(1));
      @(posedge clk);
      #1;
      force_busy = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      reset_checks("rst_mid");
      exp_q.delete();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      force_busy = 1'b0;
      cnt_a = 0;
      cnt_b = 0;
      for (int k = 0; k < 30; k++) begin
         @(negedge clk);
         if (rsp_valid) cnt_a++;
         if (fp_inst_valid) cnt_b++;
         @(posedge clk);
         #1;
      end
      chk("post_rst_no_rsp", 128'(cnt_a), 128'(0));
      chk("post_rst_no_inst", 128'(cnt_b), 128'(0));
      chk("post_rst_busy", 128'(busy), 128'(0));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/fpadd_dispatch.md
FPADD_DISPATCH -- requirements
Module: fpadd_dispatch

Interface
REQ-001 SHALL have parameter PARAM_FIFO_DEPTH, default 2: request FIFO entries (power of two, 2..8).
REQ-002 SHALL have parameter PARAM_TIMEOUT, default 15: maximum cycles allowed in WAIT_BUSY plus WAIT_DONE before the operation is aborted.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port req_valid  input  1  upstream request valid.
REQ-006 SHALL have port req_ready  output  1  FIFO can accept; equals (count < PARAM_FIFO_DEPTH).
REQ-007 SHALL have ports req_s0, req_s1  input  128 each  operand vectors.
REQ-008 SHALL have port req_mode  input  1  0 = 8 lanes x fp16, 1 = 4 lanes x fp32.
REQ-009 SHALL have port req_tag  input  4  opaque ID, returned with the result.
REQ-010 SHALL have port rsp_valid  output  1  result valid.
REQ-011 SHALL have port rsp_ready  input  1  downstream accept.
REQ-012 SHALL have port rsp_data  output  128  sum vector.
REQ-013 SHALL have port rsp_tag  output  4  tag of the completed request.
REQ-014 SHALL have port rsp_err  output  1  timeout flag; when 1, rsp_data is zero.
REQ-015 SHALL have ports fp_inst_valid  output  1 and fp_s0, fp_s1  output  128 each  adder issue side.
REQ-016 SHALL have port fp_mode  output  1  adder mode select.
REQ-017 SHALL have ports fp_idle  input  1 and fp_result  input  128  adder status and output register.
REQ-018 SHALL have port busy  output  1  high whenever state != IDLE or FIFO is non-empty.

Function
REQ-019 SHALL accept a request on a cycle with req_valid && req_ready, writing {s0, s1, mode, tag} at the FIFO tail.
REQ-020 SHALL drive fp_s0, fp_s1 and fp_mode combinationally from the FIFO head entry.
REQ-021 SHALL implement the states IDLE, ISSUE, WAIT_BUSY, WAIT_DONE and RESP.
REQ-022 IDLE SHALL go to ISSUE when the FIFO is non-empty; otherwise it SHALL stay in IDLE.
REQ-023 In ISSUE, fp_inst_valid SHALL equal fp_idle.
REQ-024 ISSUE with fp_idle=1 SHALL pop the head, latch its tag into an in-flight register, clear the timeout counter and go to WAIT_BUSY.
REQ-025 ISSUE with fp_idle=0 SHALL hold state with no pop.
REQ-026 fp_inst_valid SHALL be 0 in every state other than ISSUE, so that it is never high for more than one cycle per operation.
REQ-027 WAIT_BUSY SHALL go to WAIT_DONE on fp_idle=0.
REQ-028 WAIT_DONE SHALL, on fp_idle=1, capture fp_result into rsp_data, set rsp_err=0, set rsp_tag to the in-flight tag and go to RESP.
REQ-029 The timeout counter SHALL increment each cycle in WAIT_BUSY and WAIT_DONE.
REQ-030 When the timeout counter reaches PARAM_TIMEOUT before completion, the block SHALL go to RESP with rsp_data=0, rsp_err=1 and rsp_tag set to the in-flight tag.
REQ-031 In RESP, rsp_valid SHALL be 1, and rsp_data, rsp_tag and rsp_err SHALL hold stable until accepted.
REQ-032 On rsp_ready in RESP, the block SHALL go to ISSUE if the FIFO is non-empty after that cycle's push, else to IDLE.
REQ-033 Latency SHALL be: request accepted in cycle T, with empty FIFO, state IDLE and fp_idle=1 -> fp_inst_valid=1 in T+2 -> rsp_valid=1 first in T+7, against the 4-cycle adder.
REQ-034 A simultaneous push and pop SHALL leave count unchanged.
REQ-035 A push while full SHALL be impossible, since req_ready=0.
REQ-036 FIFO pointers SHALL wrap modulo PARAM_FIFO_DEPTH.
REQ-037 Results SHALL return in request order with at most one operation in flight.
REQ-038 Throughput SHALL be one operation per 6 cycles with rsp_ready held at 1.

Reset
REQ-039 On rst_n=0, state SHALL be IDLE and FIFO count, pointers and timeout counter SHALL be 0.
REQ-040 On rst_n=0, rsp_valid, rsp_err, rsp_tag, rsp_data and fp_inst_valid SHALL be 0.
REQ-041 On rst_n=0, req_ready SHALL be 1 and busy SHALL be 0.
REQ-042 Reset mid-operation SHALL discard the in-flight operation and all queued requests, with no response generated for any of them.

Verification
REQ-043 Bench SHALL cover: fp16, all lanes 0x3C00+0x3C00, tag 5, rsp_ready=1 -> rsp_data = 8 lanes of 0x4000, rsp_tag=5, rsp_err=0, rsp_valid exactly at T+7.
REQ-044 Bench SHALL cover: fp32, all lanes 0x3F800000+0x40000000 -> 4 lanes of 0x40400000.
REQ-045 Bench SHALL cover: three back-to-back requests (tags 1, 2, 3) with rsp_ready=0 -> req_ready falls after two accepted; the third is accepted only after RESP is released; responses arrive in tag order 1, 2, 3.
REQ-046 Bench SHALL cover: fp_idle held 1 permanently after issue -> rsp_err=1 and rsp_data=0 after PARAM_TIMEOUT cycles, followed by recovery to IDLE.
REQ-047 Bench SHALL cover: fp_idle=0 when the FIFO becomes non-empty -> fp_inst_valid stays 0 until fp_idle=1, then pulses for exactly one cycle.
REQ-048 Bench SHALL cover: rst_n asserted in WAIT_DONE with 1 request queued -> all outputs take their reset values and no response follows after reset is released.
